// File: rtl/pwm_mc_pkg.sv
// Shared register map, CTRL bit positions and address decoder for the PWM
// output stage.
package pwm_mc_pkg;

  localparam logic [6:0] ADDR_OUT_EN = 7'h00;
  localparam logic [6:0] ADDR_PWM_EN = 7'h04;
  localparam logic [6:0] ADDR_POL    = 7'h08;
  localparam logic [6:0] ADDR_PRESC  = 7'h0C;
  localparam logic [6:0] ADDR_CTRL   = 7'h0D;
  localparam logic [6:0] ADDR_DUTY   = 7'h20;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_LOAD = 1;

  typedef enum logic [2:0] {
    REG_NONE, REG_OUT_EN, REG_PWM_EN, REG_POL, REG_PRESC, REG_CTRL, REG_DUTY
  } reg_sel_e;

  // Banks and duty slots beyond the configured channel count decode to REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [6:0] addr, input int num_ch);
    int a;
    int banks;
    a     = int'(addr);
    banks = num_ch / 8;
    if (a >= int'(ADDR_DUTY) && a < int'(ADDR_DUTY) + num_ch) return REG_DUTY;
    if (a >= int'(ADDR_OUT_EN) && a < int'(ADDR_OUT_EN) + banks) return REG_OUT_EN;
    if (a >= int'(ADDR_PWM_EN) && a < int'(ADDR_PWM_EN) + banks) return REG_PWM_EN;
    if (a >= int'(ADDR_POL) && a < int'(ADDR_POL) + banks) return REG_POL;
    if (addr == ADDR_PRESC) return REG_PRESC;
    if (addr == ADDR_CTRL) return REG_CTRL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/pwm_multichannel_if.sv
// Byte-wide register write port from the SPI front end.
interface pwm_multichannel_if;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_mc_channel.sv
// One PWM channel: mode select, duty compare, polarity and output register.
module pwm_mc_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty_act,
  input  logic             out_en,
  input  logic             pwm_en,
  input  logic             pol,
  input  logic             run,
  output logic             pwm_out
);
  localparam logic [CNT_W-1:0] DUTY_FULL = '1;

  logic raw;
  logic pwm_out_d, pwm_out_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    raw = 1'b0;
    if (out_en) begin
      if (!pwm_en)                    raw = 1'b1;
      else if (!run)                  raw = 1'b0;
      else if (duty_act == '0)        raw = 1'b0;
      else if (duty_act == DUTY_FULL) raw = 1'b1;
      else                            raw = (cnt < duty_act);
    end
    // A disabled channel stays low regardless of polarity.
    pwm_out_d = raw ^ (pol & out_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked blocks use <= so every flop samples pre-edge values; = is for always_comb only.
    if (!rst_n) pwm_out_q <= 1'b0;
    else        pwm_out_q <= pwm_out_d;
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: register file, prescaler, shared period counter and
// double-buffered duty load feeding NUM_CH channel slices.
module pwm_multichannel
  import pwm_mc_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_multichannel_if.slave wr,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam int               IDX_W   = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]  out_en_d, out_en_q, pwm_en_d, pwm_en_q, pol_d, pol_q;
  logic [PRESC_W-1:0] presc_d, presc_q, pc_d, pc_q;
  logic               run_d, run_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [CNT_W-1:0]   duty_sh_d  [NUM_CH];
  logic [CNT_W-1:0]   duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]   duty_act_d [NUM_CH];
  logic [CNT_W-1:0]   duty_act_q [NUM_CH];
  logic               period_start_d, period_start_q;
  reg_sel_e           sel;
  logic               tick, wrap, load;

  always_comb begin
    sel       = decode_addr(wr.wr_addr, NUM_CH);
    out_en_d  = out_en_q;
    pwm_en_d  = pwm_en_q;
    pol_d     = pol_q;
    presc_d   = presc_q;
    run_d     = run_q;
    duty_sh_d = duty_sh_q;
    if (wr.wr_en) begin
      unique case (sel)
        REG_OUT_EN: out_en_d[8*int'(wr.wr_addr[1:0]) +: 8] = wr.wr_data;
        REG_PWM_EN: pwm_en_d[8*int'(wr.wr_addr[1:0]) +: 8] = wr.wr_data;
        REG_POL:    pol_d[8*int'(wr.wr_addr[1:0]) +: 8]    = wr.wr_data;
        REG_PRESC:  presc_d = wr.wr_data[PRESC_W-1:0];
        REG_CTRL:   run_d   = wr.wr_data[CTRL_RUN];
        REG_DUTY:   duty_sh_d[wr.wr_addr[IDX_W-1:0]] = wr.wr_data[CNT_W-1:0];
        default: ;
      endcase
    end

    tick = run_q && (pc_q == presc_q);
    wrap = tick && (cnt_q == CNT_MAX);
    // The load copies the pre-write shadow; a same-cycle DUTY write waits for the next load.
    load = wrap || !run_q ||
           (wr.wr_en && (sel == REG_CTRL) && wr.wr_data[CTRL_LOAD]);

    pc_d           = (!run_q || tick) ? '0 : pc_q + 1'b1;
    cnt_d          = !run_q ? '0 : (tick ? cnt_q + 1'b1 : cnt_q);
    duty_act_d     = load ? duty_sh_q : duty_act_q;
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q       <= '0;
      pwm_en_q       <= '0;
      pol_q          <= '0;
      presc_q        <= '0;
      run_q          <= 1'b0;
      pc_q           <= '0;
      cnt_q          <= '0;
      // NOTE: the duty arrays are plain flops with architectural reset values, so they are reset too.
      duty_sh_q      <= '{default: '0};
      duty_act_q     <= '{default: '0};
      period_start_q <= 1'b0;
    end else begin
      out_en_q       <= out_en_d;
      pwm_en_q       <= pwm_en_d;
      pol_q          <= pol_d;
      presc_q        <= presc_d;
      run_q          <= run_d;
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      duty_sh_q      <= duty_sh_d;
      duty_act_q     <= duty_act_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_mc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt      (cnt_q),
      .duty_act (duty_act_q[i]),
      .out_en   (out_en_q[i]),
      .pwm_en   (pwm_en_q[i]),
      .pol      (pol_q[i]),
      .run      (run_q),
      .pwm_out  (out[i])
    );
  end

  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: directed scenarios plus random
// register traffic, compared every cycle against a time-based reference model.
module tb_pwm_multichannel;
  localparam int NC     = 16;
  localparam int PERIOD = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multichannel_if bus ();
  logic [NC-1:0] out;
  logic          period_start;

  pwm_multichannel #(.NUM_CH(NC), .CNT_W(8), .PRESC_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (bus),
    .out          (out),
    .period_start (period_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counter position is derived from elapsed running clocks.
  logic [NC-1:0] m_oe, m_pe, m_pol, m_out;
  logic [7:0]    m_presc;
  logic          m_run, m_ps;
  logic [7:0]    m_sh  [NC];
  logic [7:0]    m_act [NC];
  int            m_k;

  function automatic int m_cnt();
    return m_run ? (m_k / (int'(m_presc) + 1)) % PERIOD : 0;
  endfunction

  function automatic logic m_wrap();
    return m_run && (((m_k + 1) % (PERIOD * (int'(m_presc) + 1))) == 0);
  endfunction

  function automatic logic [NC-1:0] m_level();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) begin
      logic lvl;
      if (!m_oe[i])                   lvl = 1'b0;
      else if (!m_pe[i])              lvl = 1'b1;
      else if (!m_run)                lvl = 1'b0;
      else if (int'(m_act[i]) == 0)   lvl = 1'b0;
      else if (int'(m_act[i]) == 255) lvl = 1'b1;
      else                            lvl = (m_cnt() < int'(m_act[i]));
      r[i] = m_oe[i] ? (lvl ^ m_pol[i]) : 1'b0;
    end
    return r;
  endfunction

  function automatic logic m_next_run();
    return (bus.wr_en && bus.wr_addr == 7'h0D) ? bus.wr_data[0] : m_run;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_oe <= '0; m_pe <= '0; m_pol <= '0; m_out <= '0;
      m_presc <= '0; m_run <= 1'b0; m_ps <= 1'b0; m_k <= 0;
      m_sh <= '{default: '0};
      m_act <= '{default: '0};
    end else begin
      m_out <= m_level();
      m_ps  <= m_wrap();
      if (m_wrap() || !m_run || (bus.wr_en && bus.wr_addr == 7'h0D && bus.wr_data[1]))
        m_act <= m_sh;
      m_k <= (m_run && m_next_run()) ? m_k + 1 : 0;
      if (bus.wr_en) begin
        if (bus.wr_addr < 7'h02)
          m_oe[8*int'(bus.wr_addr[0]) +: 8] <= bus.wr_data;
        else if (bus.wr_addr >= 7'h04 && bus.wr_addr < 7'h06)
          m_pe[8*int'(bus.wr_addr[0]) +: 8] <= bus.wr_data;
        else if (bus.wr_addr >= 7'h08 && bus.wr_addr < 7'h0A)
          m_pol[8*int'(bus.wr_addr[0]) +: 8] <= bus.wr_data;
        else if (bus.wr_addr == 7'h0C)
          m_presc <= bus.wr_data;
        else if (bus.wr_addr == 7'h0D)
          m_run <= bus.wr_data[0];
        else if (int'(bus.wr_addr) >= 32 && int'(bus.wr_addr) < 32 + NC)
          m_sh[int'(bus.wr_addr) - 32] <= bus.wr_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("out", 32'(out), 32'(m_out));
      check("period_start", 32'(period_start), 32'(m_ps));
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (period_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("ps_seen", 32'(found), 32'(1));
  endtask

  // Counts the current sample plus n-1 further ones.
  task automatic count_high(input int n, input int ch, output int highs, output int pss);
    highs = int'(out[ch]);
    pss   = int'(period_start);
    for (int i = 1; i < n; i++) begin
      step(1);
      highs += int'(out[ch]);
      pss   += int'(period_start);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, p, h1, h2;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'(0));
    check("reset_ps", 32'(period_start), 32'(0));
    rst_n = 1'b1;
    step(2);

    // 50% duty on ch0, 25% on ch3, prescale 0
    wr(7'h00, 8'h09); wr(7'h04, 8'h09);
    wr(7'h20, 8'h80); wr(7'h23, 8'h40);
    wr(7'h0C, 8'h00); wr(7'h0D, 8'h01);
    wait_ps(600);
    count_high(256, 0, h, p);
    check("duty50_high", 32'(h), 32'(128));
    check("duty50_ps_per_period", 32'(p), 32'(1));
    step(1);
    check("ps_at_256", 32'(period_start), 32'(1));
    count_high(256, 3, h, p);
    check("ch3_duty40_high", 32'(h), 32'(64));

    // Double buffer: mid-period DUTY write waits for the wrap
    step(1);
    count_high(128, 3, h1, p);
    wr(7'h23, 8'hC0);
    count_high(128, 3, h2, p);
    check("dbuf_old_duty_kept", 32'(h1 + h2), 32'(64));
    step(1);
    check("dbuf_ps", 32'(period_start), 32'(1));
    count_high(256, 3, h, p);
    check("dbuf_new_duty", 32'(h), 32'(192));

    // LOAD strobe applies the shadow on the next clk
    step(1);
    wr(7'h23, 8'h40);
    step(99);
    check("load_before", 32'(out[3]), 32'(1));
    wr(7'h0D, 8'h03);
    step(1);
    check("load_after", 32'(out[3]), 32'(0));

    // Extremes over two periods
    wr(7'h20, 8'h00); wr(7'h0D, 8'h03); step(2);
    count_high(512, 0, h, p);
    check("duty00_high", 32'(h), 32'(0));
    wr(7'h20, 8'hFF); wr(7'h0D, 8'h03); step(2);
    count_high(512, 0, h, p);
    check("dutyFF_high", 32'(h), 32'(512));
    check("dutyFF_ps", 32'(p), 32'(2));

    // Prescaler 3: 1024-clk period, 0x10 duty -> 64 clks high
    wr(7'h0D, 8'h00); wr(7'h0C, 8'h03); wr(7'h20, 8'h10); wr(7'h0D, 8'h01);
    wait_ps(1200);
    count_high(1024, 0, h, p);
    check("presc_high", 32'(h), 32'(64));
    check("presc_ps", 32'(p), 32'(1));

    // Modes and polarity on ch1
    wr(7'h00, 8'h0B); step(2);
    check("static_high", 32'(out[1]), 32'(1));
    wr(7'h08, 8'h02); step(2);
    check("static_high_inverted", 32'(out[1]), 32'(0));
    wr(7'h00, 8'h09); step(2);
    check("disabled_ignores_pol", 32'(out[1]), 32'(0));

    // Unmapped addresses and out-of-range banks/channels are ignored
    wr(7'h30, 8'h00); wr(7'h0E, 8'h00); wr(7'h02, 8'hFF);
    wr(7'h06, 8'hFF); wr(7'h0A, 8'hFF);
    wait_ps(1200);
    count_high(1024, 0, h, p);
    check("ignored_writes_high", 32'(h), 32'(64));
    check("ignored_writes_ps", 32'(p), 32'(1));

    // Random register traffic checked cycle by cycle
    for (int r = 0; r < 4; r++) begin
      wr(7'h0D, 8'h00);
      wr(7'h0C, 8'($urandom_range(0, 2)));
      wr(7'h0D, 8'h01);
      for (int j = 0; j < 40; j++) begin
        int kind;
        logic [7:0] d;
        kind = $urandom_range(0, 4);
        d    = 8'($urandom);
        case (kind)
          0: wr(7'h00 + 7'($urandom_range(0, 1)), d);
          1: wr(7'h04 + 7'($urandom_range(0, 1)), d);
          2: wr(7'h08 + 7'($urandom_range(0, 1)), d);
          3: begin
            case ($urandom_range(0, 3))
              0: d = 8'h00;
              1: d = 8'hFF;
              default: ;
            endcase
            wr(7'h20 + 7'($urandom_range(0, NC - 1)), d);
          end
          default: wr(7'h0D, 8'($urandom_range(0, 3)));
        endcase
        step($urandom_range(1, 40));
      end
    end

    // Asynchronous reset mid-run
    wr(7'h0D, 8'h00); wr(7'h0C, 8'h00);
    wr(7'h00, 8'h01); wr(7'h01, 8'h00);
    wr(7'h04, 8'h01); wr(7'h05, 8'h00);
    wr(7'h08, 8'h00); wr(7'h09, 8'h00);
    wr(7'h20, 8'h80); wr(7'h0D, 8'h01);
    step(10);
    check("pre_reset_high", 32'(out[0]), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(out), 32'(0));
    check("async_reset_ps", 32'(period_start), 32'(0));
    step(2);
    rst_n = 1'b1;
    step(5);
    wr(7'h0D, 8'h01);
    count_high(300, 0, h, p);
    check("post_reset_oe_cleared", 32'(h), 32'(0));
    wr(7'h00, 8'h01); step(2);
    check("post_reset_pwm_en_pol_cleared", 32'(out[0]), 32'(1));
    wr(7'h04, 8'h01); step(2);
    count_high(300, 0, h, p);
    check("post_reset_duty_cleared", 32'(h), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
